// File: rtl/vliw_issue_scheduler.sv
// vliw_issue_scheduler: scoreboard issue controller for the VLIW execute slots.
// Tracks in-flight destination registers with per-register latency countdowns,
// holds a bundle while any slot has a RAW/WAW hazard, issues a registered pulse
// with a slot mask, and offers a drain sequence.
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   i_bundle_valid      decoded bundle present
//   o_bundle_ready      combinational; bundle accepted when valid && ready
//   i_slot_valid/wen    per-slot op present / writes a destination register
//   i_slot_rd/rs1/rs2   per-slot register indices, slot s at [s*REGW +: REGW]
//   i_slot_lat          per-slot result latency, slot s at [s*LATW +: LATW]
//   i_flush             synchronous scoreboard clear (priority over everything)
//   i_drain_req         stop accepting until all results retire
//   o_issue_valid/mask  registered issue pulse and slot mask
//   o_drain_done        one-cycle pulse when a drain completes
//   o_conflict_err      registered pulse: two writing slots share an rd
//   o_busy_vec          bit r set while register r has a result in flight
//   o_stall_cnt         saturating count of stalled cycles
// Build option: define SCHED_BYPASS_EN to treat a source whose counter is 1
// as ready (forwarded in the issue cycle).
module vliw_issue_scheduler #(
    parameter int NSLOT = 8,
    parameter int NREG  = 32,
    parameter int REGW  = 5,
    parameter int LATW  = 3,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_bundle_valid,
    output logic                  o_bundle_ready,
    input  logic [NSLOT-1:0]      i_slot_valid,
    input  logic [NSLOT-1:0]      i_slot_wen,
    input  logic [NSLOT*REGW-1:0] i_slot_rd,
    input  logic [NSLOT*REGW-1:0] i_slot_rs1,
    input  logic [NSLOT*REGW-1:0] i_slot_rs2,
    input  logic [NSLOT*LATW-1:0] i_slot_lat,
    input  logic                  i_flush,
    input  logic                  i_drain_req,
    output logic                  o_issue_valid,
    output logic [NSLOT-1:0]      o_issue_mask,
    output logic                  o_drain_done,
    output logic                  o_conflict_err,
    output logic [NREG-1:0]       o_busy_vec,
    output logic [CNTW-1:0]       o_stall_cnt
);
    typedef enum logic {S_RUN, S_DRAIN} state_t;
    state_t           r_state, w_state_nxt;
    logic [LATW-1:0]  r_cnt [NREG];
    logic [LATW-1:0]  w_cnt_nxt [NREG];
    logic             r_issue_valid, r_conflict_err;
    logic [NSLOT-1:0] r_issue_mask;
    logic [CNTW-1:0]  r_stall_cnt;
    logic [NSLOT-1:0] w_wr;
    logic             w_hazard, w_conflict, w_accept;

    function automatic logic f_src_busy(input logic [LATW-1:0] c);
`ifdef SCHED_BYPASS_EN
        return c > LATW'(1);
`else
        return c != '0;
`endif
    endfunction

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_busy
            assign o_busy_vec[g] = r_cnt[g] != '0;
        end
        for (g = 0; g < NSLOT; g++) begin : g_wr
            assign w_wr[g] = i_slot_valid[g] && i_slot_wen[g] && i_slot_rd[g*REGW +: REGW] != '0;
        end
    endgenerate

    // Hazards are judged against pre-bundle counters, so slots of one bundle never block each other.
    always_comb begin
        w_hazard   = 1'b0;
        w_conflict = 1'b0;
        for (int s = 0; s < NSLOT; s++) begin
            if (i_slot_valid[s] && (f_src_busy(r_cnt[i_slot_rs1[s*REGW +: REGW]]) ||
                                    f_src_busy(r_cnt[i_slot_rs2[s*REGW +: REGW]]) ||
                                    (i_slot_wen[s] && r_cnt[i_slot_rd[s*REGW +: REGW]] != '0)))
                w_hazard = 1'b1;
            for (int t = s + 1; t < NSLOT; t++)
                if (w_wr[s] && w_wr[t] && i_slot_rd[s*REGW +: REGW] == i_slot_rd[t*REGW +: REGW])
                    w_conflict = 1'b1;
        end
    end

    // A drain request blocks the bundle presented in the same cycle.
    assign o_bundle_ready = r_state == S_RUN && !w_hazard && !i_flush && !i_drain_req;
    assign w_accept       = i_bundle_valid && o_bundle_ready;

    // Later slots overwrite earlier ones, so the highest-index writer's latency wins.
    always_comb begin
        for (int r = 0; r < NREG; r++)
            w_cnt_nxt[r] = (i_flush || r_cnt[r] == '0) ? '0 : r_cnt[r] - 1'b1;
        if (w_accept)
            for (int s = 0; s < NSLOT; s++)
                if (w_wr[s] && i_slot_lat[s*LATW +: LATW] != '0)
                    w_cnt_nxt[i_slot_rd[s*REGW +: REGW]] = i_slot_lat[s*LATW +: LATW];
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_drain_done = 1'b0;
        if (i_flush)
            w_state_nxt = S_RUN;
        else if (r_state == S_RUN && i_drain_req)
            w_state_nxt = S_DRAIN;
        else if (r_state == S_DRAIN && o_busy_vec == '0) begin
            o_drain_done = 1'b1;
            w_state_nxt  = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_RUN;
            r_issue_valid  <= 1'b0;
            r_issue_mask   <= '0;
            r_conflict_err <= 1'b0;
            r_stall_cnt    <= '0;
            for (int r = 0; r < NREG; r++)
                r_cnt[r] <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_issue_valid  <= w_accept;
            r_issue_mask   <= w_accept ? i_slot_valid : '0;
            r_conflict_err <= w_accept && w_conflict;
            if (i_bundle_valid && !o_bundle_ready && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            for (int r = 0; r < NREG; r++)
                r_cnt[r] <= w_cnt_nxt[r];
        end
    end

    assign o_issue_valid  = r_issue_valid;
    assign o_issue_mask   = r_issue_mask;
    assign o_conflict_err = r_conflict_err;
    assign o_stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_vliw_issue_scheduler.sv
// tb_vliw_issue_scheduler: directed bench for vliw_issue_scheduler.
module tb_vliw_issue_scheduler;
    localparam int NSLOT = 8, NREG = 32, REGW = 5, LATW = 3, CNTW = 16;
`ifdef SCHED_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    logic clk = 1'b0;
    logic rst_n;
    logic i_bundle_valid, o_bundle_ready, i_flush, i_drain_req;
    logic [NSLOT-1:0] i_slot_valid, i_slot_wen;
    logic [NSLOT*REGW-1:0] i_slot_rd, i_slot_rs1, i_slot_rs2;
    logic [NSLOT*LATW-1:0] i_slot_lat;
    logic o_issue_valid, o_drain_done, o_conflict_err;
    logic [NSLOT-1:0] o_issue_mask;
    logic [NREG-1:0] o_busy_vec;
    logic [CNTW-1:0] o_stall_cnt;
    int n_chk = 0, n_err = 0;

    vliw_issue_scheduler #(.NSLOT(NSLOT), .NREG(NREG), .REGW(REGW), .LATW(LATW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .i_bundle_valid(i_bundle_valid), .o_bundle_ready(o_bundle_ready),
        .i_slot_valid(i_slot_valid), .i_slot_wen(i_slot_wen), .i_slot_rd(i_slot_rd),
        .i_slot_rs1(i_slot_rs1), .i_slot_rs2(i_slot_rs2), .i_slot_lat(i_slot_lat),
        .i_flush(i_flush), .i_drain_req(i_drain_req), .o_issue_valid(o_issue_valid),
        .o_issue_mask(o_issue_mask), .o_drain_done(o_drain_done), .o_conflict_err(o_conflict_err),
        .o_busy_vec(o_busy_vec), .o_stall_cnt(o_stall_cnt));

    always #5 clk = ~clk;

    typedef struct {
        bit bv, fl, dr;
        int s0, rd0, a0, b0, l0;
        int s1, rd1, a1, b1, l1;
        bit er, ei;
        logic [7:0] em;
        bit ec;
        logic [31:0] eb;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        i_bundle_valid = 0; i_flush = 0; i_drain_req = 0;
        i_slot_valid = '0; i_slot_wen = '0;
        i_slot_rd = '0; i_slot_rs1 = '0; i_slot_rs2 = '0; i_slot_lat = '0;
    endtask

    task automatic put_op(input int s, input int rd, input int a, input int b, input int l);
        i_slot_valid[s] = 1'b1;
        i_slot_wen[s] = 1'b1;
        i_slot_rd[s*REGW +: REGW] = REGW'(rd);
        i_slot_rs1[s*REGW +: REGW] = REGW'(a);
        i_slot_rs2[s*REGW +: REGW] = REGW'(b);
        i_slot_lat[s*LATW +: LATW] = LATW'(l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        clear_in();
        i_bundle_valid = v.bv; i_flush = v.fl; i_drain_req = v.dr;
        if (v.s0 >= 0) put_op(v.s0, v.rd0, v.a0, v.b0, v.l0);
        if (v.s1 >= 0) put_op(v.s1, v.rd1, v.a1, v.b1, v.l1);
        #1;
        chk($sformatf("v%0d.ready", k), 64'(o_bundle_ready), 64'(v.er));
        tick();
        chk($sformatf("v%0d.issue", k), 64'(o_issue_valid), 64'(v.ei));
        chk($sformatf("v%0d.mask", k), 64'(o_issue_mask), 64'(v.em));
        chk($sformatf("v%0d.conflict", k), 64'(o_conflict_err), 64'(v.ec));
        chk($sformatf("v%0d.busy", k), 64'(o_busy_vec), 64'(v.eb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int stalls, dn;
        //         bv fl dr  s0 rd0 a0 b0 l0  s1 rd1 a1 b1 l1  er ei em     ec eb
        tbl[0]  = '{1, 0, 0,  0,  7, 0, 0, 2,  5,  7, 0, 0, 6,  1, 1, 8'h21, 1, 32'h0000_0080};
        tbl[1]  = '{1, 0, 0,  2,  7, 0, 0, 1, -1,  0, 0, 0, 0,  0, 0, 8'h00, 0, 32'h0000_0080};
        tbl[2]  = '{1, 0, 0,  3,  0, 0, 7, 0, -1,  0, 0, 0, 0,  0, 0, 8'h00, 0, 32'h0000_0080};
        tbl[3]  = '{1, 0, 0,  1,  8, 9, 0, 3, -1,  0, 0, 0, 0,  1, 1, 8'h02, 0, 32'h0000_0180};
        tbl[4]  = '{0, 0, 0, -1,  0, 0, 0, 0, -1,  0, 0, 0, 0,  1, 0, 8'h00, 0, 32'h0000_0180};
        tbl[5]  = '{0, 0, 0, -1,  0, 0, 0, 0, -1,  0, 0, 0, 0,  1, 0, 8'h00, 0, 32'h0000_0180};
        tbl[6]  = '{0, 0, 0, -1,  0, 0, 0, 0, -1,  0, 0, 0, 0,  1, 0, 8'h00, 0, 32'h0000_0000};
        tbl[7]  = '{1, 0, 0,  0,  0, 0, 0, 7, -1,  0, 0, 0, 0,  1, 1, 8'h01, 0, 32'h0000_0000};
        tbl[8]  = '{1, 0, 0,  4,  0, 0, 0, 0, -1,  0, 0, 0, 0,  1, 1, 8'h10, 0, 32'h0000_0000};
        tbl[9]  = '{1, 0, 0,  0, 12, 0, 0, 3,  6,  0,12, 0, 0,  1, 1, 8'h41, 0, 32'h0000_1000};
        tbl[10] = '{0, 0, 0, -1,  0, 0, 0, 0, -1,  0, 0, 0, 0,  1, 0, 8'h00, 0, 32'h0000_1000};
        tbl[11] = '{0, 0, 0, -1,  0, 0, 0, 0, -1,  0, 0, 0, 0,  1, 0, 8'h00, 0, 32'h0000_1000};
        tbl[12] = '{1, 0, 0,  0,  0, 0, 0, 2,  1,  0, 0, 0, 3,  1, 1, 8'h03, 0, 32'h0000_0000};

        rst_n = 1'b0;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(o_busy_vec), 64'h0);
        chk("rst.issue", 64'(o_issue_valid), 64'h0);
        chk("rst.mask", 64'(o_issue_mask), 64'h0);
        chk("rst.stall", 64'(o_stall_cnt), 64'h0);
        chk("rst.done", 64'(o_drain_done), 64'h0);
        rst_n = 1'b1;

        // RAW stall on r3 behind a latency-4 producer
        clear_in(); i_bundle_valid = 1; put_op(0, 3, 0, 0, 4);
        #1; chk("raw.ready1", 64'(o_bundle_ready), 64'h1);
        tick();
        chk("raw.issue1", 64'(o_issue_valid), 64'h1);
        chk("raw.mask1", 64'(o_issue_mask), 64'h01);
        chk("raw.busy1", 64'(o_busy_vec), 64'h8);
        clear_in(); i_bundle_valid = 1; put_op(1, 0, 3, 0, 0);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_bundle_ready) break;
            stalls++;
            tick();
        end
        chk("raw.stalls", 64'(stalls), 64'(4 - BYP));
        tick();
        chk("raw.issue2", 64'(o_issue_valid), 64'h1);
        chk("raw.mask2", 64'(o_issue_mask), 64'h02);
        chk("raw.stall_cnt", 64'(o_stall_cnt), 64'(4 - BYP));

        for (int k = 0; k < 13; k++) run_vec(tbl[k], k);

        // drain while r9 is in flight, with a bundle waiting
        clear_in(); i_bundle_valid = 1; put_op(0, 9, 0, 0, 5);
        tick();
        chk("drn.busy", 64'(o_busy_vec), 64'h200);
        clear_in(); i_bundle_valid = 1; put_op(2, 0, 0, 0, 0); i_drain_req = 1;
        #1; chk("drn.ready_req", 64'(o_bundle_ready), 64'h0);
        tick();
        i_drain_req = 0;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_drain_done) begin
                dn = k + 1;
                break;
            end
            tick();
        end
        chk("drn.cycles", 64'(dn), 64'd5);
        chk("drn.busy_at_done", 64'(o_busy_vec), 64'h0);
        chk("drn.ready_at_done", 64'(o_bundle_ready), 64'h0);
        tick(); #1;
        chk("drn.done_once", 64'(o_drain_done), 64'h0);
        chk("drn.ready_after", 64'(o_bundle_ready), 64'h1);
        tick();
        chk("drn.issue", 64'(o_issue_valid), 64'h1);
        chk("drn.mask", 64'(o_issue_mask), 64'h04);

        // drain with nothing in flight completes the next cycle
        clear_in(); i_drain_req = 1;
        tick();
        i_drain_req = 0;
        #1; chk("drn0.done", 64'(o_drain_done), 64'h1);
        tick(); #1;
        chk("drn0.done_once", 64'(o_drain_done), 64'h0);
        tick();

        // flush two cycles after r4 goes busy
        clear_in(); i_bundle_valid = 1; put_op(0, 4, 0, 0, 7);
        tick();
        clear_in(); i_bundle_valid = 1; put_op(1, 0, 4, 0, 0);
        #1; chk("fl.ready_a", 64'(o_bundle_ready), 64'h0);
        tick();
        #1; chk("fl.ready_b", 64'(o_bundle_ready), 64'h0);
        tick();
        i_flush = 1;
        #1; chk("fl.ready_flush", 64'(o_bundle_ready), 64'h0);
        tick();
        i_flush = 0;
        chk("fl.busy", 64'(o_busy_vec), 64'h0);
        chk("fl.no_issue", 64'(o_issue_valid), 64'h0);
        #1; chk("fl.ready_after", 64'(o_bundle_ready), 64'h1);
        tick();
        chk("fl.issue", 64'(o_issue_valid), 64'h1);
        chk("fl.mask", 64'(o_issue_mask), 64'h02);

        // issue pending at a flush still completes
        clear_in(); i_bundle_valid = 1; put_op(3, 0, 0, 0, 0);
        tick();
        clear_in(); i_flush = 1;
        chk("flp.issue", 64'(o_issue_valid), 64'h1);
        chk("flp.mask", 64'(o_issue_mask), 64'h08);
        tick();
        i_flush = 0;
        chk("flp.issue_after", 64'(o_issue_valid), 64'h0);

        // flush beats a simultaneous drain request
        clear_in(); i_flush = 1; i_drain_req = 1; i_bundle_valid = 1;
        tick();
        clear_in(); i_bundle_valid = 1;
        #1;
        chk("fld.ready", 64'(o_bundle_ready), 64'h1);
        chk("fld.done", 64'(o_drain_done), 64'h0);
        tick();
        chk("fld.issue", 64'(o_issue_valid), 64'h1);

        // asynchronous reset mid-drain and mid-countdown
        clear_in(); i_bundle_valid = 1; put_op(0, 5, 0, 0, 7);
        tick();
        clear_in(); i_bundle_valid = 1; put_op(1, 0, 5, 0, 0); i_drain_req = 1;
        tick();
        i_drain_req = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 64'(o_busy_vec), 64'h0);
        chk("arst.issue", 64'(o_issue_valid), 64'h0);
        chk("arst.stall", 64'(o_stall_cnt), 64'h0);
        chk("arst.done", 64'(o_drain_done), 64'h0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst.ready", 64'(o_bundle_ready), 64'h1);
        chk("arst.done2", 64'(o_drain_done), 64'h0);
        tick();
        chk("arst.issue2", 64'(o_issue_valid), 64'h1);
        chk("arst.mask2", 64'(o_issue_mask), 64'h02);
        chk("arst.stall2", 64'(o_stall_cnt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
